// File: rtl/cpu6_pkg.sv
// Shared definitions for the 6-bit CPU datapath: widths, opcodes,
// controller state encoding and the program-entry record.
package cpu6_pkg;

  localparam int unsigned DATA_W     = 6;
  localparam int unsigned PROG_DEPTH = 8;
  localparam int unsigned ADDR_W     = $clog2(PROG_DEPTH);

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              op;
  } prog_entry_t;

endpackage

// File: rtl/alu_controller_if.sv
// Operand/opcode bundle from the sequencer to the sibling ALU.
interface alu_controller_if;
  import cpu6_pkg::*;

  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              OP;

  modport master (output A, output B, output OP);
  modport slave  (input  A, input  B, input  OP);

endinterface

// File: rtl/ctrl_prog_rom.sv
// Fixed 8-entry stimulus program: combinational address -> {A, B, OP}.
module ctrl_prog_rom
  import cpu6_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  output prog_entry_t       entry_o
);

  // Each entry is chosen to exercise a distinct ALU corner (zero, wrap, borrow).
  always_comb begin
    entry_o = '{a: 6'd0, b: 6'd0, op: OP_ADD};
    unique case (addr_i)
      3'd0: entry_o = '{a: 6'd5,  b: 6'd3,  op: OP_ADD};
      3'd1: entry_o = '{a: 6'd5,  b: 6'd3,  op: OP_SUB};
      3'd2: entry_o = '{a: 6'd7,  b: 6'd7,  op: OP_SUB};
      3'd3: entry_o = '{a: 6'd63, b: 6'd1,  op: OP_ADD};
      3'd4: entry_o = '{a: 6'd0,  b: 6'd1,  op: OP_SUB};
      3'd5: entry_o = '{a: 6'd21, b: 6'd42, op: OP_ADD};
      3'd6: entry_o = '{a: 6'd32, b: 6'd32, op: OP_ADD};
      3'd7: entry_o = '{a: 6'd10, b: 6'd4,  op: OP_SUB};
      default: entry_o = '{a: 6'd0, b: 6'd0, op: OP_ADD};
    endcase
  end

endmodule

// File: rtl/alu_controller.sv
// Sequencer that steps the ALU through the fixed program, holding each
// entry for STEP_CYCLES clocks; registered outputs only.
module alu_controller
  import cpu6_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 1,
  parameter bit          WRAP        = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  alu_controller_if.master alu_o
);

  localparam logic [3:0] HOLD_MAX = 4'(STEP_CYCLES - 1);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [3:0]        hold_q, hold_d;
  prog_entry_t       out_q, out_d;
  logic [ADDR_W-1:0] romAddr;
  prog_entry_t       romEntry;

  // Leaving IDLE always loads entry 0; otherwise look one entry ahead,
  // letting the 3-bit index wrap 7 -> 0 on its own.
  assign romAddr = (state_q == IDLE) ? '0 : ADDR_W'(step_q + 1'b1);

  ctrl_prog_rom u_rom (
    .addr_i  (romAddr),
    .entry_o (romEntry)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    hold_d  = hold_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        state_d = RUN;
        step_d  = '0;
        hold_d  = '0;
        out_d   = romEntry;
      end
      RUN: begin
        if (hold_q == HOLD_MAX) begin
          hold_d = '0;
          if (step_q == ADDR_W'(PROG_DEPTH - 1) && !WRAP) begin
            state_d = DONE;
          end else begin
            step_d = romAddr;
            out_d  = romEntry;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      hold_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end

  assign alu_o.A  = out_q.a;
  assign alu_o.B  = out_q.b;
  assign alu_o.OP = out_q.op;

endmodule

// File: tb/tb_alu_controller.sv
// Bench for alu_controller: three instances (step 1 wrap, step 3 wrap,
// step 1 halt) checked against a time-indexed model of the program.
module tb_alu_controller;
  import cpu6_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3, rstH;
  int   n1, n3, nH;
  int   checks = 0;
  int   failures = 0;

  localparam int PROG_A[8]  = '{5, 5, 7, 63, 0, 21, 32, 10};
  localparam int PROG_B[8]  = '{3, 3, 7, 1, 1, 42, 32, 4};
  localparam int PROG_OP[8] = '{0, 1, 1, 0, 1, 0, 0, 1};

  typedef struct {
    int a;
    int b;
    int op;
    int result;
    int zf;
  } vec_t;

  vec_t vecs[9];

  alu_controller_if if1 ();
  alu_controller_if if3 ();
  alu_controller_if ifH ();

  alu_controller #(.STEP_CYCLES(1), .WRAP(1'b1)) dut1 (.clk(clk), .reset(rst1), .alu_o(if1));
  alu_controller #(.STEP_CYCLES(3), .WRAP(1'b1)) dut3 (.clk(clk), .reset(rst3), .alu_o(if3));
  alu_controller #(.STEP_CYCLES(1), .WRAP(1'b0)) dutH (.clk(clk), .reset(rstH), .alu_o(ifH));

  function automatic int packOut(int a, int b, int op);
    return (a << 7) | (b << 1) | op;
  endfunction

  // n = rising edges since reset release; entry k is shown from edge 1 + k*s.
  function automatic int modelOut(int n, int s, bit wrap);
    int k;
    if (n == 0) return 0;
    k = (n - 1) / s;
    if (wrap) k = k % 8;
    else if (k > 7) k = 7;
    return packOut(PROG_A[k], PROG_B[k], PROG_OP[k]);
  endfunction

  function automatic int aluResult(int a, int b, int op);
    return op ? ((a - b) & 63) : ((a + b) & 63);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "/s1w"}, packOut(int'(if1.A), int'(if1.B), int'(if1.OP)), modelOut(n1, 1, 1'b1));
    checkOutput({tag, "/s3w"}, packOut(int'(if3.A), int'(if3.B), int'(if3.OP)), modelOut(n3, 3, 1'b1));
    checkOutput({tag, "/s1h"}, packOut(int'(ifH.A), int'(ifH.B), int'(ifH.OP)), modelOut(nH, 1, 1'b0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst1) n1++;
    if (rst3) n3++;
    if (rstH) nH++;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      checkAll("run");
    end
  endtask

  // Reset is asserted between edges so any change must come from the async path.
  task automatic midReset(input logic [2:0] mask, input int hold);
    #2;
    if (mask[0]) begin rst1 = 1'b0; n1 = 0; end
    if (mask[1]) begin rst3 = 1'b0; n3 = 0; end
    if (mask[2]) begin rstH = 1'b0; nH = 0; end
    #1;
    checkAll("async_reset");
    for (int i = 0; i <= hold; i++) begin
      tick();
      checkAll("reset_held");
    end
    if (mask[0]) rst1 = 1'b1;
    if (mask[1]) rst3 = 1'b1;
    if (mask[2]) rstH = 1'b1;
  endtask

  initial begin
    int tries;
    vecs[0] = '{5, 3, 0, 8, 0};
    vecs[1] = '{5, 3, 1, 2, 0};
    vecs[2] = '{7, 7, 1, 0, 1};
    vecs[3] = '{63, 1, 0, 0, 1};
    vecs[4] = '{0, 1, 1, 63, 0};
    vecs[5] = '{21, 42, 0, 63, 0};
    vecs[6] = '{32, 32, 0, 0, 1};
    vecs[7] = '{10, 4, 1, 6, 0};
    vecs[8] = '{5, 3, 0, 8, 0};

    rst1 = 1'b0; rst3 = 1'b0; rstH = 1'b0;
    n1 = 0; n3 = 0; nH = 0;
    #10;
    tick();
    tick();
    checkAll("reset_low");
    rst1 = 1'b1; rst3 = 1'b1; rstH = 1'b1;

    for (int i = 0; i < 9; i++) begin
      int r;
      tick();
      checkAll("table_model");
      checkOutput($sformatf("table_entry%0d", i),
                  packOut(int'(if1.A), int'(if1.B), int'(if1.OP)),
                  packOut(vecs[i].a, vecs[i].b, vecs[i].op));
      r = aluResult(int'(if1.A), int'(if1.B), int'(if1.OP));
      checkOutput($sformatf("table_result%0d", i), r, vecs[i].result);
      checkOutput($sformatf("table_zf%0d", i), int'(r == 0), vecs[i].zf);
      if (i == 3)
        checkOutput("s3_entry1_at_edge4", packOut(int'(if3.A), int'(if3.B), int'(if3.OP)), packOut(5, 3, 1));
    end

    tries = 0;
    while (((n1 - 1) % 8) != 4 && tries < 16) begin
      tick();
      checkAll("seek_entry4");
      tries++;
    end
    checkOutput("seek_entry4_found", (n1 - 1) % 8, 4);
    checkOutput("entry4_shown", packOut(int'(if1.A), int'(if1.B), int'(if1.OP)), packOut(0, 1, 1));
    midReset(3'b001, 1);
    checkOutput("midreset_zero", packOut(int'(if1.A), int'(if1.B), int'(if1.OP)), 0);
    tick();
    checkAll("after_midreset");
    checkOutput("restart_entry0", packOut(int'(if1.A), int'(if1.B), int'(if1.OP)), packOut(5, 3, 0));

    while (nH < 40) begin
      tick();
      checkAll("halt_run");
    end
    checkOutput("halt_hold", packOut(int'(ifH.A), int'(ifH.B), int'(ifH.OP)), packOut(10, 4, 1));
    midReset(3'b100, 0);
    tick();
    checkOutput("halt_restart", packOut(int'(ifH.A), int'(ifH.B), int'(ifH.OP)), packOut(5, 3, 0));

    for (int iter = 0; iter < 40; iter++) begin
      logic [2:0] mask;
      applyStimulus(int'($urandom_range(1, 25)));
      mask = 3'($urandom_range(0, 7));
      if (mask != 3'b000) midReset(mask, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
